// File: rtl/calculations.sv
// rtl/calculations.sv - execute-stage datapath slice: operand registers, operand muxes, ALU, ALUOut register and flags
module calculations #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] input_A,
  input  logic [WIDTH-1:0] input_B,
  input  logic [WIDTH-1:0] input_PC,
  input  logic [WIDTH-1:0] input_imm,
  input  logic [3:0]       input_ALUOp,
  input  logic [1:0]       input_ALUSrcA,
  input  logic [1:0]       input_ALUSrcB,
  input  logic             input_PCSrc,
  output logic [WIDTH-1:0] output_ALUMuxOut,
  output logic [WIDTH-1:0] output_ALUOut_sr,
  output logic [WIDTH-1:0] output_B_sr,
  output logic             output_Zero,
  output logic             output_negative,
  output logic             output_carry
);

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] alu_out_q, alu_out_d;
  logic [WIDTH-1:0] op_a, op_b, result;
  logic [WIDTH:0]   wide;
  logic [3:0]       shamt;
  logic             carry;

  always_comb begin
    case (input_ALUSrcA)
      2'b01:   op_a = '0;
      2'b10:   op_a = a_q;
      default: op_a = input_PC;
    endcase
    case (input_ALUSrcB)
      2'b00:   op_b = b_q;
      2'b01:   op_b = WIDTH'(2);
      2'b10:   op_b = input_imm;
      default: op_b = input_imm << 1;
    endcase
  end

  // Shifts run one bit wider so the last bit shifted out lands in the spare bit;
  // a zero shift amount leaves that spare bit at 0.
  always_comb begin
    result = '0;
    carry  = 1'b0;
    wide   = '0;
    shamt  = op_b[3:0];
    case (input_ALUOp)
      4'b0000: begin
        wide   = {1'b0, op_a} + {1'b0, op_b};
        result = wide[WIDTH-1:0];
        carry  = wide[WIDTH];
      end
      4'b0001: begin
        wide   = {1'b0, op_a} + {1'b0, ~op_b} + (WIDTH+1)'(1);
        result = wide[WIDTH-1:0];
        carry  = wide[WIDTH];
      end
      4'b0010: result = op_a & op_b;
      4'b0011: result = op_a | op_b;
      4'b0100: result = op_a ^ op_b;
      4'b0101: result = ~op_a;
      4'b0110: begin
        wide   = {1'b0, op_a} << shamt;
        result = wide[WIDTH-1:0];
        carry  = wide[WIDTH];
      end
      4'b0111: begin
        wide   = {op_a, 1'b0} >> shamt;
        result = wide[WIDTH:1];
        carry  = wide[0];
      end
      4'b1000: begin
        wide   = $unsigned($signed({op_a, 1'b0}) >>> shamt);
        result = wide[WIDTH:1];
        carry  = wide[0];
      end
      4'b1001: result = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      4'b1010: result = op_b;
      default: result = '0;
    endcase
  end

  always_comb begin
    a_d       = input_A;
    b_d       = input_B;
    alu_out_d = result;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q       <= '0;
      b_q       <= '0;
      alu_out_q <= '0;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      alu_out_q <= alu_out_d;
    end
  end

  assign output_ALUMuxOut = input_PCSrc ? alu_out_q : result;
  assign output_ALUOut_sr = alu_out_q;
  assign output_B_sr      = b_q;
  assign output_Zero      = (result == '0);
  assign output_negative  = result[WIDTH-1];
  assign output_carry     = carry;

endmodule

// File: tb/tb_calculations.sv
// tb/tb_calculations.sv - randomized self-checking bench for calculations against an arithmetic reference model
module tb_calculations;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] input_A, input_B, input_PC, input_imm;
  logic [3:0]  input_ALUOp;
  logic [1:0]  input_ALUSrcA, input_ALUSrcB;
  logic        input_PCSrc;
  logic [15:0] output_ALUMuxOut, output_ALUOut_sr, output_B_sr;
  logic        output_Zero, output_negative, output_carry;

  int total = 0;
  int bad   = 0;

  // reference register contents
  int m_a, m_b, m_alu;

  calculations #(.WIDTH(16)) dut (
    .clk              (clk),
    .reset            (reset),
    .input_A          (input_A),
    .input_B          (input_B),
    .input_PC         (input_PC),
    .input_imm        (input_imm),
    .input_ALUOp      (input_ALUOp),
    .input_ALUSrcA    (input_ALUSrcA),
    .input_ALUSrcB    (input_ALUSrcB),
    .input_PCSrc      (input_PCSrc),
    .output_ALUMuxOut (output_ALUMuxOut),
    .output_ALUOut_sr (output_ALUOut_sr),
    .output_B_sr      (output_B_sr),
    .output_Zero      (output_Zero),
    .output_negative  (output_negative),
    .output_carry     (output_carry)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (op=%0d srcA=%0d srcB=%0d pcsrc=%0d)",
               tag, got, exp, input_ALUOp, input_ALUSrcA, input_ALUSrcB, input_PCSrc);
    end
  endtask

  function automatic int sgn(input int v);
    return (v >= 32768) ? v - 65536 : v;
  endfunction

  function automatic void ref_alu(input int op, input int sa, input int sb, input int ra, input int rb,
                                  input int pc, input int imm, output int r, output int c);
    int x, y, n;
    case (sa)
      1:       x = 0;
      2:       x = ra;
      default: x = pc;
    endcase
    case (sb)
      0:       y = rb;
      1:       y = 2;
      2:       y = imm;
      default: y = (imm * 2) % 65536;
    endcase
    n = y % 16;
    c = 0;
    case (op)
      0:  begin r = (x + y) % 65536; c = (x + y) / 65536; end
      1:  begin r = (x - y + 65536) % 65536; c = (x >= y) ? 1 : 0; end
      2:  r = x & y;
      3:  r = x | y;
      4:  r = x ^ y;
      5:  r = 65535 - x;
      6:  begin r = (x * (1 << n)) % 65536; c = (n == 0) ? 0 : (x / (1 << (16 - n))) % 2; end
      7:  begin r = x / (1 << n); c = (n == 0) ? 0 : (x / (1 << (n - 1))) % 2; end
      8:  begin r = (sgn(x) >>> n) & 65535; c = (n == 0) ? 0 : (x / (1 << (n - 1))) % 2; end
      9:  r = (sgn(x) < sgn(y)) ? 1 : 0;
      10: r = y;
      default: r = 0;
    endcase
  endfunction

  task automatic check_all(input string tag);
    int r, c;
    ref_alu(input_ALUOp, input_ALUSrcA, input_ALUSrcB, m_a, m_b, input_PC, input_imm, r, c);
    chk({tag, ".mux"},  output_ALUMuxOut, input_PCSrc ? m_alu : r);
    chk({tag, ".aluq"}, output_ALUOut_sr, m_alu);
    chk({tag, ".bq"},   output_B_sr, m_b);
    chk({tag, ".zero"}, output_Zero, (r == 0) ? 1 : 0);
    chk({tag, ".neg"},  output_negative, (r >= 32768) ? 1 : 0);
    chk({tag, ".carry"}, output_carry, c);
  endtask

  // Called just after a falling edge: drive, take one rising edge, update model, check.
  task automatic step(input string tag, input logic [15:0] a, input logic [15:0] b, input logic [15:0] pc,
                      input logic [15:0] imm, input logic [3:0] op, input logic [1:0] sa,
                      input logic [1:0] sb, input logic pcs);
    int r, c;
    input_A = a; input_B = b; input_PC = pc; input_imm = imm;
    input_ALUOp = op; input_ALUSrcA = sa; input_ALUSrcB = sb; input_PCSrc = pcs;
    ref_alu(op, sa, sb, m_a, m_b, pc, imm, r, c);
    @(posedge clk);
    m_alu = r; m_a = a; m_b = b;
    #1;
    check_all(tag);
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    #2;
    reset = 1'b0;
    m_a = 0; m_b = 0; m_alu = 0;
    #1;
    chk("rst.aluq_async", output_ALUOut_sr, 0);
    chk("rst.bq_async", output_B_sr, 0);
    check_all("rst.mid");
    @(posedge clk);
    #1;
    check_all("rst.hold");
    @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    reset = 1'b0;
    input_A = 16'h0; input_B = 16'h0; input_PC = 16'h0; input_imm = 16'h0;
    input_ALUOp = 4'b0000; input_ALUSrcA = 2'b10; input_ALUSrcB = 2'b00; input_PCSrc = 1'b0;
    m_a = 0; m_b = 0; m_alu = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.aluq", output_ALUOut_sr, 16'h0000);
    chk("reset.bq", output_B_sr, 16'h0000);
    chk("reset.mux", output_ALUMuxOut, 16'h0000);
    chk("reset.zero", output_Zero, 1'b1);
    @(negedge clk);
    reset = 1'b1;

    step("t1", 16'h0001, 16'h0002, 16'h0, 16'h0, 4'b0000, 2'b10, 2'b00, 1'b0);
    chk("t1.val", output_ALUMuxOut, 16'h0003);
    step("t2a", 16'h1234, 16'h5678, 16'h0, 16'h0, 4'b0000, 2'b10, 2'b00, 1'b0);
    chk("t2a.val", output_ALUMuxOut, 16'h68AC);
    step("t2b", 16'h1234, 16'h5678, 16'h0, 16'h0, 4'b0000, 2'b10, 2'b00, 1'b1);
    chk("t2b.aluq", output_ALUOut_sr, 16'h68AC);
    chk("t2b.mux", output_ALUMuxOut, 16'h68AC);
    chk("t2b.bq", output_B_sr, 16'h5678);
    step("t3", 16'h0BCD, 16'h0, 16'h0, 16'h0111, 4'b0001, 2'b10, 2'b10, 1'b0);
    chk("t3.val", output_ALUMuxOut, 16'h0ABC);
    chk("t3.carry", output_carry, 1'b1);
    step("t4", 16'h0, 16'h0, 16'h1234, 16'h0, 4'b0000, 2'b00, 2'b01, 1'b0);
    chk("t4.val", output_ALUMuxOut, 16'h1236);
    step("t5", 16'h5555, 16'h5555, 16'h0, 16'h0, 4'b0001, 2'b10, 2'b00, 1'b0);
    chk("t5.zero", output_Zero, 1'b1);
    step("t6", 16'h5555, 16'h5585, 16'h0, 16'h0, 4'b0001, 2'b10, 2'b00, 1'b0);
    chk("t6.val", output_ALUMuxOut, 16'hFFD0);
    chk("t6.neg", output_negative, 1'b1);
    chk("t6.carry", output_carry, 1'b0);
    step("t7", 16'h8001, 16'h0001, 16'h0, 16'h0, 4'b1000, 2'b10, 2'b00, 1'b0);
    chk("t7.sra", output_ALUMuxOut, 16'hC000);
    chk("t7.carry", output_carry, 1'b1);

    reset_pulse();
    step("post_rst", 16'h00F0, 16'h000F, 16'h0, 16'h0, 4'b0011, 2'b10, 2'b00, 1'b0);
    chk("post_rst.or", output_ALUMuxOut, 16'h00FF);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) reset_pulse();
      step("rnd", rnd16(), rnd16(), rnd16(), rnd16(), 4'($urandom_range(0, 15)),
           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
